piso_tx: RTL
============

Name: piso_tx

Overview:
Parallel-in serial-out transmitter. It sits directly upstream of the 4-bit SIPO shift register and feeds it.
- Accepts an N-bit word over a valid/ready handshake.
- Shifts the word out MSB-first, one bit per clock, with a bit-valid qualifier and frame markers.
- Inserts an optional idle gap between frames.
- Because the bits are MSB-first, after N shifts the SIPO's po equals the transmitted word (first bit lands in po[N-1]).

Parameters:
N, 4, word width in bits (N >= 2)
GAP, 0, idle cycles inserted after each frame before the next word can be accepted (0 allows back-to-back frames)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
pi  input  N  parallel word to transmit
pi_valid  input  1  pi holds a valid word
pi_ready  output  1  transmitter can accept a word this cycle
so  output  1  serial data bit (connects to SIPO si)
so_valid  output  1  so carries a frame bit this cycle
frame_start  output  1  pulse marking the first bit of a frame
frame_end  output  1  pulse marking the last bit of a frame
busy  output  1  high while in SHIFT or GAP

Behaviour:
- One clock (clk). Reset is synchronous and active-high: reset is sampled only on the rising edge of clk.
- Reset values: state=IDLE, shift register=0, counters=0, so=0, so_valid=0, frame_start=0, frame_end=0, busy=0.
- pi_ready is combinational from state. It is 0 while reset is high.
- All other outputs are registered.
- Handshake: a word is accepted on the rising edge where pi_valid && pi_ready.
  - pi is captured into the shift register at that edge.
  - pi_valid while pi_ready=0 is ignored. Nothing is queued.
  - pi may change freely after acceptance.
- States:
  - IDLE: pi_ready=1. On accept -> SHIFT, with bit counter = N-1.
  - SHIFT: each cycle, so = current MSB and so_valid=1.
    - Shift register shifts left, zero-filled. Bit counter decrements.
    - frame_start=1 on the first SHIFT cycle only. frame_end=1 on the cycle where bit counter = 0.
    - When bit counter = 0:
      - If GAP>0 -> GAP, with gap counter = GAP-1.
      - If GAP=0 -> IDLE. pi_ready=1 during this last bit cycle, so a word accepted here starts SHIFT on the next cycle with no bubble (new frame_start).
  - GAP: so=0, so_valid=0, pi_ready=0. Gap counter decrements. At 0 -> IDLE.
- Latency: word accepted at edge k -> first bit (MSB) valid in the cycle after edge k. The last bit (LSB) is valid N cycles after acceptance.
- Throughput: one frame per N+GAP cycles, plus 1 idle cycle when GAP>0 (IDLE re-entry).
- so=0 whenever so_valid=0.
- Counter widths: bit counter $clog2(N); gap counter $clog2(GAP+1), minimum 1 bit.
- Boundary conditions:
  - Reset mid-SHIFT or mid-GAP: next cycle is IDLE, all outputs 0, and the partial frame is dropped. The downstream SIPO is reset by the same signal.
  - pi_valid held high continuously: with GAP=0, words are sent back-to-back; with GAP>0, one word every N+GAP+1 cycles.
  - pi_valid asserted in the same cycle reset is high: not accepted.

Decomposition:
- Shared package (shift_pkg): state enum {IDLE, SHIFT, GAP} and a clog2 helper function.
- No sub-module: FSM, shift register and counters fit in one module.
- The existing SIPO is instantiated only in the loopback bench.

Test Plan:
- Reset, then N=4, pi=4'b1011 with pulse pi_valid -> so=1,0,1,1 on cycles 1-4 after accept; so_valid high for exactly 4 cycles; frame_start at bit 1; frame_end at bit 4; pi_ready low cycles 1-3.
- GAP=0, pi_valid held with 4'b1100 then 4'b0011 -> 8 contiguous so_valid cycles giving 1,1,0,0,0,0,1,1; frame_start at cycles 1 and 5.
- GAP=2, two words 4'b1001, 4'b0110 -> 2 cycles with so_valid=0 plus 1 IDLE cycle between frames; second frame_start 7 cycles after the first.
- pi_valid pulsed with 4'b1111 during SHIFT of 4'b0000 -> ignored; output stays 0,0,0,0; only one frame sent.
- Assert reset after bit 2 of 4'b1010 -> next cycle so=0, so_valid=0, busy=0, pi_ready=1 after reset drops; a new word transmits correctly.
- Loopback into SIPO (same clk/reset), random words -> SIPO po equals the sent word on the cycle after frame_end, for 100 words.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and helpers for the serial transmit path: FSM state encoding
// and a width helper that never returns zero.
package shift_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_e;

  // Bits needed to count 0..value-1; at least 1 so a zero-length counter never appears.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Word handshake plus serial frame outputs of the PISO transmitter.
// master = word producer / frame consumer, slave = piso_tx.
interface piso_tx_if #(
  parameter int N = 4
) ();

  logic [N-1:0] pi;
  logic         pi_valid;
  logic         pi_ready;
  logic         so;
  logic         so_valid;
  logic         frame_start;
  logic         frame_end;
  logic         busy;

  modport master (
    output pi, pi_valid,
    input  pi_ready, so, so_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  pi, pi_valid,
    output pi_ready, so, so_valid, frame_start, frame_end, busy
  );

endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts an N-bit word, sends it MSB-first
// with frame markers, then optionally idles GAP cycles before the next word.
module piso_tx
  import shift_pkg::*;
#(
  parameter int N   = 4,
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  piso_tx_if.slave   bus
);

  localparam int BW = clog2_min1(N);
  localparam int GW = clog2_min1(GAP + 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(N - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  state_e        state_q;
  logic [N-1:0]  sreg_q;
  logic [BW-1:0] bit_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic          so_q;
  logic          so_valid_q;
  logic          frame_start_q;
  logic          frame_end_q;
  logic          busy_q;

  logic last_bit;
  logic pi_ready;
  logic accept;

  // With no gap the last bit cycle also accepts, so frames run back-to-back.
  assign last_bit = (state_q == S_SHIFT) && (bit_cnt_q == '0);
  assign pi_ready = !reset && ((state_q == S_IDLE) || ((GAP == 0) && last_bit));
  assign accept   = bus.pi_valid && pi_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sreg_q        <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      so_q          <= 1'b0;
      so_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      if (accept) begin
        // MSB goes out straight away; the rest waits in the shift register.
        state_q       <= S_SHIFT;
        sreg_q        <= {bus.pi[N-2:0], 1'b0};
        bit_cnt_q     <= BIT_LOAD;
        so_q          <= bus.pi[N-1];
        so_valid_q    <= 1'b1;
        frame_start_q <= 1'b1;
        busy_q        <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
          S_SHIFT: begin
            if (bit_cnt_q != '0) begin
              so_q        <= sreg_q[N-1];
              sreg_q      <= {sreg_q[N-2:0], 1'b0};
              bit_cnt_q   <= bit_cnt_q - 1'b1;
              frame_end_q <= (bit_cnt_q == BW'(1));
            end else if (GAP > 0) begin
              state_q    <= S_GAP;
              gap_cnt_q  <= GAP_LOAD;
              so_q       <= 1'b0;
              so_valid_q <= 1'b0;
            end else begin
              state_q    <= S_IDLE;
              so_q       <= 1'b0;
              so_valid_q <= 1'b0;
              busy_q     <= 1'b0;
            end
          end
          S_GAP: begin
            if (gap_cnt_q == '0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              gap_cnt_q <= gap_cnt_q - 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.pi_ready    = pi_ready;
  assign bus.so          = so_q;
  assign bus.so_valid    = so_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.busy        = busy_q;

endmodule
